// File: rtl/load_store_unit_if.sv
// Core-side request/response and data-memory signals of the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_DataWr;
    logic        mem_DMWr;
    logic [2:0]  mem_DMCtrl;
    logic [31:0] mem_DataRd;

    // The LSU itself.
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_DataRd,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_address, mem_DataWr, mem_DMWr, mem_DMCtrl
    );

    // The core plus data memory surrounding the LSU.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_DataRd,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_address, mem_DataWr, mem_DMWr, mem_DMCtrl
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time, drives the data memory
// for one aligned beat or N byte beats (misaligned), then pulses a response.
//
// state  | meaning
// IDLE   | req_ready=1, waiting for req_valid
// ACCESS | driving one memory beat (byte beats when split)
// RESP   | one-cycle resp_valid pulse, then back to IDLE
module load_store_unit #(
    parameter int ADDR_LIMIT       = 128,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic        split_q;
    logic [1:0]  beats_left_q;
    logic [1:0]  byte_idx_q;
    logic [31:0] asm_q;

    logic [2:0]  size_m1;
    logic        bad_code;
    logic        misaligned;
    logic [32:0] last_byte;
    logic        req_illegal;
    logic        accept;
    logic [31:0] load_result;
    logic [31:0] wshift;

    // Classify the presented request: size, alignment and legality.
    always_comb begin
        size_m1  = 3'd0;
        bad_code = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b100: size_m1 = 3'd0;
            3'b001, 3'b101: size_m1 = 3'd1;
            3'b010:         size_m1 = 3'd3;
            default:        bad_code = 1'b1;
        endcase
        misaligned  = (bus.req_addr[1:0] & size_m1[1:0]) != 2'b00;
        // 33-bit sum so an address near 2^32 cannot wrap into range
        last_byte   = {1'b0, bus.req_addr} + {30'd0, size_m1};
        req_illegal = bad_code
                    | (bus.req_we & bus.req_funct3[2])
                    | (last_byte >= 33'(ADDR_LIMIT))
                    | (misaligned & ~SPLIT_MISALIGNED);
        accept      = (state_q == IDLE) & bus.req_valid;
    end

    // Final load value: split halfwords need extension, other cases come back ready.
    always_comb begin
        load_result = asm_q;
        if (split_q) begin
            case (funct3_q)
                3'b001:  load_result = {{16{asm_q[15]}}, asm_q[15:0]};
                3'b101:  load_result = {16'd0, asm_q[15:0]};
                default: load_result = asm_q;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and all bus outputs; memory outputs are zero outside ACCESS.
    always_comb begin
        state_d         = state_q;
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_err    = 1'b0;
        bus.resp_rdata  = 32'd0;
        bus.mem_address = 32'd0;
        bus.mem_DataWr  = 32'd0;
        bus.mem_DMWr    = 1'b0;
        bus.mem_DMCtrl  = 3'b000;
        wshift          = wdata_q >> {byte_idx_q, 3'b000};
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = req_illegal ? RESP : ACCESS;
            end
            ACCESS: begin
                bus.mem_DMWr = we_q;
                if (split_q) begin
                    bus.mem_address = addr_q + {30'd0, byte_idx_q};
                    bus.mem_DMCtrl  = we_q ? 3'b000 : 3'b100;
                    bus.mem_DataWr  = we_q ? {24'd0, wshift[7:0]} : 32'd0;
                end else begin
                    bus.mem_address = addr_q;
                    bus.mem_DMCtrl  = funct3_q;
                    bus.mem_DataWr  = we_q ? wdata_q : 32'd0;
                end
                if (beats_left_q == 2'd0) state_d = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                bus.resp_rdata = (err_q | we_q) ? 32'd0 : load_result;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, beat down-counter and load assembly buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            err_q        <= 1'b0;
            split_q      <= 1'b0;
            beats_left_q <= 2'd0;
            byte_idx_q   <= 2'd0;
            asm_q        <= 32'd0;
        end else if (accept) begin
            we_q         <= bus.req_we;
            funct3_q     <= bus.req_funct3;
            addr_q       <= bus.req_addr;
            wdata_q      <= bus.req_wdata;
            err_q        <= req_illegal;
            split_q      <= misaligned & ~req_illegal;
            beats_left_q <= (misaligned & ~req_illegal) ? size_m1[1:0] : 2'd0;
            byte_idx_q   <= 2'd0;
            asm_q        <= 32'd0;
        end else if (state_q == ACCESS) begin
            if (beats_left_q != 2'd0) begin
                beats_left_q <= beats_left_q - 2'd1;
                byte_idx_q   <= byte_idx_q + 2'd1;
            end
            if (!we_q) begin
                if (split_q) asm_q[{byte_idx_q, 3'b000} +: 8] <= bus.mem_DataRd[7:0];
                else         asm_q <= bus.mem_DataRd;
            end
        end
    end
endmodule
